// File: rtl/bkt_fwd_task_engine.sv
// Task engine: ap_ctrl_hs control, header + N-beat frame forwarder with stall timeout.
// Define BKT_FWD_CHECKSUM_EN to append an XOR trailer beat after the payload.
module bkt_fwd_task_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_ready,
  output logic                  ap_idle,
  output logic                  ap_local_deadlock,
  input  logic [31:0]           reg0_i,
  input  logic [31:0]           reg1_i,
  input  logic [31:0]           reg2_i,
  output logic [31:0]           reg3_o,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_DRAIN,
    S_PAD,
    S_DONE,
    S_CSUM
  } state_t;

  state_t                state_q;
  logic [LEN_WIDTH-1:0]  n_q;
  logic [LEN_WIDTH-1:0]  beat_q;
  logic [31:0]           tmo_q;
  logic [31:0]           stall_q;
  logic                  err_q;
  logic                  idle_q;
  logic                  ready_q;
  logic                  done_q;
  logic                  dl_q;
  logic                  mvalid_q;
  logic                  mlast_q;
  logic [DATA_WIDTH-1:0] mdata_q;
`ifdef BKT_FWD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;
`endif

  logic [LEN_WIDTH-1:0]  n_d;
  logic [LEN_WIDTH-1:0]  nm1;
  logic [31:0]           stall_d;
  logic                  s_hs;
  logic                  m_hs;
  logic                  is_last;
  logic                  stalled;
  logic                  unused_reg0;

  assign n_d         = reg0_i[LEN_WIDTH-1:0];
  assign unused_reg0 = ^reg0_i[31:LEN_WIDTH];
  assign nm1         = n_q - LEN_WIDTH'(1);
  assign stall_d     = stall_q + 32'd1;

  assign s_axis_tready = (state_q == S_DATA) &
                         (!mvalid_q | m_axis_tready);
  assign s_hs    = s_axis_tvalid & s_axis_tready;
  assign m_hs    = mvalid_q & m_axis_tready;
  assign is_last = (beat_q == nm1);
  // Only a starved input with an empty output register counts as a stall.
  assign stalled = (tmo_q != 32'd0) & !s_axis_tvalid & !mvalid_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      beat_q   <= '0;
      tmo_q    <= '0;
      stall_q  <= '0;
      err_q    <= 1'b0;
      idle_q   <= 1'b1;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      dl_q     <= 1'b0;
      mvalid_q <= 1'b0;
      mlast_q  <= 1'b0;
      mdata_q  <= '0;
`ifdef BKT_FWD_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      dl_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ap_start) begin
            ready_q  <= 1'b1;
            idle_q   <= 1'b0;
            n_q      <= n_d;
            tmo_q    <= reg2_i;
            beat_q   <= '0;
            stall_q  <= '0;
            err_q    <= 1'b0;
            mvalid_q <= 1'b1;
            mdata_q  <= DATA_WIDTH'(reg1_i);
`ifdef BKT_FWD_CHECKSUM_EN
            mlast_q  <= 1'b0;
            csum_q   <= DATA_WIDTH'(reg1_i);
`else
            mlast_q  <= (n_d == '0);
`endif
            state_q  <= S_HDR;
          end
        end
        S_HDR: begin
          if (m_axis_tready) begin
            mvalid_q <= 1'b0;
            if (n_q != '0) begin
              state_q <= S_DATA;
            end else begin
`ifdef BKT_FWD_CHECKSUM_EN
              state_q <= S_CSUM;
`else
              state_q <= S_DONE;
`endif
            end
          end
        end
        S_DATA: begin
          if (m_hs) begin
            mvalid_q <= 1'b0;
          end
          if (s_hs) begin
            mvalid_q <= 1'b1;
            mdata_q  <= s_axis_tdata;
            beat_q   <= beat_q + LEN_WIDTH'(1);
            stall_q  <= '0;
`ifdef BKT_FWD_CHECKSUM_EN
            mlast_q  <= 1'b0;
            csum_q   <= csum_q ^ s_axis_tdata;
            if (is_last) begin
              state_q <= S_CSUM;
            end
`else
            mlast_q  <= is_last;
            if (is_last) begin
              state_q <= S_DRAIN;
            end
`endif
          end else if (stalled) begin
            if (stall_d == tmo_q) begin
              err_q    <= 1'b1;
              dl_q     <= 1'b1;
              mvalid_q <= 1'b1;
              mdata_q  <= '0;
              mlast_q  <= 1'b1;
              state_q  <= S_PAD;
            end else begin
              stall_q <= stall_d;
            end
          end else begin
            stall_q <= '0;
          end
        end
`ifdef BKT_FWD_CHECKSUM_EN
        S_CSUM: begin
          if (!mvalid_q || m_axis_tready) begin
            mvalid_q <= 1'b1;
            mdata_q  <= csum_q;
            mlast_q  <= 1'b1;
            state_q  <= S_DRAIN;
          end
        end
`endif
        S_DRAIN, S_PAD: begin
          if (m_axis_tready) begin
            mvalid_q <= 1'b0;
            mlast_q  <= 1'b0;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          idle_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ap_done           = done_q;
  assign ap_ready          = ready_q;
  assign ap_idle           = idle_q;
  assign ap_local_deadlock = dl_q;
  assign m_axis_tvalid     = mvalid_q;
  assign m_axis_tlast      = mlast_q;
  assign m_axis_tdata      = mdata_q;
  assign reg3_o = {!idle_q, err_q, {(30-LEN_WIDTH){1'b0}}, beat_q};

endmodule

// File: tb/tb_bkt_fwd_task_engine.sv
// Scoreboard bench for bkt_fwd_task_engine: directed tasks, queue-based frame checker.
module tb_bkt_fwd_task_engine;

`ifdef BKT_FWD_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        ap_start;
  logic        ap_done, ap_ready, ap_idle, ap_local_deadlock;
  logic [31:0] reg0_i, reg1_i, reg2_i, reg3_o;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;

  bkt_fwd_task_engine dut (
    .ACLK              (ACLK),
    .ARESET            (ARESET),
    .ap_start          (ap_start),
    .ap_done           (ap_done),
    .ap_ready          (ap_ready),
    .ap_idle           (ap_idle),
    .ap_local_deadlock (ap_local_deadlock),
    .reg0_i            (reg0_i),
    .reg1_i            (reg1_i),
    .reg2_i            (reg2_i),
    .reg3_o            (reg3_o),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tready     (m_axis_tready)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_e;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          rdy_cnt, done_cnt, dl_cnt;
  int          last_mhs, done_gap, dl_gap;
  bit          srdy_seen;
  bit          stall_prev = 1'b0;
  logic [33:0] prev_m;
  logic [31:0] reg3_done;
  logic [31:0] pay[16];

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] pword(int i);
    return (i < 16) ? pay[i] : 32'(i);
  endfunction

  always @(negedge ACLK) begin
    cyc++;
    if (!ARESET) begin
      if (s_axis_tready) srdy_seen = 1'b1;
      if (ap_ready) rdy_cnt++;
      if (ap_done) begin
        done_cnt++;
        done_gap  = cyc - last_mhs;
        reg3_done = reg3_o;
      end
      if (ap_local_deadlock) begin
        dl_cnt++;
        dl_gap = cyc - last_mhs;
      end
      if (stall_prev)
        chk("hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, prev_m);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_beat: got %0h expected none", m_axis_tdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_data", m_axis_tdata, mon_e.data);
          chk("beat_last", m_axis_tlast, mon_e.last);
        end
        last_mhs = cyc;
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      prev_m     = {m_axis_tvalid, m_axis_tlast, m_axis_tdata};
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Expected frame: header, payload (cut short on timeout), then pad or trailer.
  task automatic push_exp(input int n, input logic [31:0] hdr,
                          input int fed, input bit tmo);
    beat_t       b;
    logic [31:0] cs;
    int          cnt;
    cs     = hdr;
    cnt    = tmo ? fed : n;
    b.last = (n == 0) && !CS;
    b.data = hdr;
    exp_q.push_back(b);
    for (int i = 0; i < cnt; i++) begin
      b.last = (i == n - 1) && !CS;
      b.data = pword(i);
      cs     = cs ^ pword(i);
      exp_q.push_back(b);
    end
    if (tmo) begin
      b.last = 1'b1;
      b.data = 32'h0;
      exp_q.push_back(b);
    end else if (CS) begin
      b.last = 1'b1;
      b.data = cs;
      exp_q.push_back(b);
    end
  endtask

  task automatic clr();
    rdy_cnt   = 0;
    done_cnt  = 0;
    dl_cnt    = 0;
    done_gap  = -1;
    dl_gap    = -1;
    srdy_seen = 1'b0;
    reg3_done = 32'hDEAD_BEEF;
  endtask

  task automatic chk_rst(string tag);
    chk({tag, "_ctl"}, {ap_idle, ap_done, ap_ready, ap_local_deadlock,
                        s_axis_tready, m_axis_tvalid, m_axis_tlast},
        7'b1000000);
    chk({tag, "_tdata"}, m_axis_tdata, 32'h0);
    chk({tag, "_reg3"}, reg3_o, 32'h0);
  endtask

  task automatic run(input int n, input logic [31:0] hdr,
                     input logic [31:0] tmo, input int feed,
                     input bit rmode, input logic [15:0] vmask,
                     input int maxc, input int abortc, output bit done);
    int idx;
    idx      = 0;
    done     = 1'b0;
    reg0_i   = 32'(n);
    reg1_i   = hdr;
    reg2_i   = tmo;
    ap_start = 1'b1;
    for (int k = 0; k < maxc; k++) begin
      m_axis_tready = rmode ? (k % 2 == 0) : 1'b1;
      s_axis_tvalid = (idx < feed) && vmask[k % 16];
      s_axis_tdata  = pword(idx);
      @(negedge ACLK);
      if (s_axis_tvalid && s_axis_tready) idx++;
      if (ap_ready) ap_start = 1'b0;
      if (ap_done) done = 1'b1;
      @(posedge ACLK);
      #1;
      if (done || (abortc != 0 && k == abortc)) break;
    end
    s_axis_tvalid = 1'b0;
    ap_start      = 1'b0;
  endtask

  initial begin
    bit ok;
    ap_start      = 1'b0;
    reg0_i        = '0;
    reg1_i        = '0;
    reg2_i        = '0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    chk_rst("in_rst");
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;
    chk_rst("post_rst");

    for (int i = 0; i < 16; i++) pay[i] = 32'(i + 1);
    clr();
    push_exp(4, 32'hA5A5_0001, 4, 1'b0);
    run(4, 32'hA5A5_0001, 0, 4, 1'b0, 16'hFFFF, 100, 0, ok);
    chk("t1_done", ok, 1);
    chk("t1_ready_pulses", rdy_cnt, 1);
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_reg3", reg3_done, 32'h0000_0004);
    chk("t1_left", exp_q.size(), 0);
    chk("t1_idle", ap_idle, 1);

    clr();
    push_exp(0, 32'h1234_5678, 0, 1'b0);
    run(0, 32'h1234_5678, 0, 0, 1'b0, 16'hFFFF, 100, 0, ok);
    chk("t2_done", ok, 1);
    chk("t2_no_sready", srdy_seen, 0);
    chk("t2_done_gap", done_gap, 2);
    chk("t2_reg3", reg3_done, 32'h0);
    chk("t2_left", exp_q.size(), 0);

    for (int i = 0; i < 3; i++) pay[i] = 32'h31 + 32'(i);
    clr();
    push_exp(3, 32'h0000_C003, 3, 1'b0);
    run(3, 32'h0000_C003, 0, 3, 1'b1, 16'hB6D3, 200, 0, ok);
    chk("t3_done", ok, 1);
    chk("t3_reg3", reg3_done, 32'h0000_0003);
    chk("t3_left", exp_q.size(), 0);

    for (int i = 0; i < 8; i++) pay[i] = 32'h41 + 32'(i);
    clr();
    push_exp(8, 32'h0000_D008, 2, 1'b1);
    run(8, 32'h0000_D008, 5, 2, 1'b0, 16'hFFFF, 100, 0, ok);
    chk("t4_done", ok, 1);
    chk("t4_dl_pulses", dl_cnt, 1);
    // Last payload leaves, then 5 empty-register cycles, then the pulse.
    chk("t4_dl_gap", dl_gap, 6);
    chk("t4_done_pulses", done_cnt, 1);
    chk("t4_reg3", reg3_done, 32'h4000_0002);
    chk("t4_left", exp_q.size(), 0);

    for (int i = 0; i < 16; i++) pay[i] = 32'h100 + 32'(i);
    clr();
    push_exp(10, 32'h0000_E00A, 10, 1'b0);
    run(10, 32'h0000_E00A, 0, 10, 1'b0, 16'hFFFF, 100, 4, ok);
    chk("t5_still_busy", reg3_o[31], 1);
    #2;
    ARESET = 1'b1;
    #1;
    chk_rst("mid_rst");
    chk("t5_no_done", done_cnt, 0);
    exp_q.delete();
    @(negedge ACLK);
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;
    clr();
    push_exp(2, 32'hBEEF_0002, 2, 1'b0);
    run(2, 32'hBEEF_0002, 0, 2, 1'b0, 16'hFFFF, 100, 0, ok);
    chk("t5b_done", ok, 1);
    chk("t5b_reg3", reg3_done, 32'h0000_0002);
    chk("t5b_left", exp_q.size(), 0);

    pay[0] = 32'h0F;
    pay[1] = 32'hFF;
    clr();
    push_exp(2, 32'hF0, 2, 1'b0);
    run(2, 32'hF0, 0, 2, 1'b0, 16'hFFFF, 100, 0, ok);
    chk("t6_done", ok, 1);
    chk("t6_left", exp_q.size(), 0);

    for (int i = 0; i < 16; i++) pay[i] = 32'h7000 + 32'(i);
    clr();
    push_exp(65535, 32'h0000_FFFF, 65535, 1'b0);
    run(65535, 32'h0000_FFFF, 0, 65535, 1'b0, 16'hFFFF, 70000, 0, ok);
    chk("t7_done", ok, 1);
    chk("t7_reg3", reg3_done, 32'h0000_FFFF);
    chk("t7_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
